// File: rtl/uart_tx_arbiter_if.sv
// Bundle between the byte-producing requesters, the arbiter and the UARTTx
// transmitter.
//   Req/ReqData : per-requester pending flag and byte (slice i = [8i+7:8i])
//   Ack         : one-cycle pulse, requester's byte accepted by UARTTx
//   Grant       : one-hot current owner of the transmitter, 0 when idle
//   LoadTx      : load strobe to UARTTx
//   TxData      : captured byte to UARTTx DataIn
//   TxBusy      : UARTTx busy flag (BitClk domain, asynchronous)
//   Busy        : arbiter not idle
//   Timeout     : one-cycle pulse, load abandoned
// master = requester/transmitter side, slave = arbiter.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   Req;
  logic [8*NUM_REQ-1:0] ReqData;
  logic [NUM_REQ-1:0]   Ack;
  logic [NUM_REQ-1:0]   Grant;
  logic                 LoadTx;
  logic [7:0]           TxData;
  logic                 TxBusy;
  logic                 Busy;
  logic                 Timeout;

  modport master (
    output Req, ReqData, TxBusy,
    input  Ack, Grant, LoadTx, TxData, Busy, Timeout
  );

  modport slave (
    input  Req, ReqData, TxBusy,
    output Ack, Grant, LoadTx, TxData, Busy, Timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UARTTx among NUM_REQ requesters.
// A winner is picked in IDLE, its byte captured, and LoadTx held until the
// synchronized TxBusy is seen (or LOAD_TIMEOUT cycles elapse). The grant is
// then held until the frame finishes.
// Ports:
//   Clk   : system clock, all state on rising edge
//   Reset : synchronous, active-high
//   bus   : uart_tx_arbiter_if.slave (request/ack/grant/UARTTx signals)
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int LOAD_TIMEOUT = 1024
) (
  input  logic             Clk,
  input  logic             Reset,
  uart_tx_arbiter_if.slave bus
);

  localparam int LW = $clog2(NUM_REQ);
  localparam int CW = $clog2(LOAD_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, LOAD, BUSY} state_t;

  state_t             state, stateNext;
  logic [1:0]         busySync;
  logic               txBusyS;
  logic [LW-1:0]      last;
  logic [LW-1:0]      grantIdx;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] ack;
  logic [7:0]         txData;
  logic               timeout;
  logic [CW-1:0]      loadCnt;
  logic               loadDone;
  logic               winValid;
  logic [LW-1:0]      winIdx;
  logic               loadTx;
  logic               busy;

  // TxBusy comes from the BitClk domain; only the synchronized copy is used.
  always_ff @(posedge Clk) begin
    if (Reset) busySync <= 2'b00;
    else       busySync <= {busySync[0], bus.TxBusy};
  end
  assign txBusyS = busySync[1];

  // Round-robin search starting just after the last served requester.
  always_comb begin
    int sum;
    logic [LW-1:0] idx;
    sum      = 0;
    idx      = '0;
    winValid = 1'b0;
    winIdx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      sum = int'(last) + k;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      idx = LW'(sum);
      if (!winValid && bus.Req[idx]) begin
        winValid = 1'b1;
        winIdx   = idx;
      end
    end
  end

  assign loadDone = (loadCnt == CW'(LOAD_TIMEOUT - 1));

  // FSM: state register
  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= stateNext;
  end

  // FSM: next state
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (winValid && !txBusyS) stateNext = LOAD;
      LOAD:    if (txBusyS)              stateNext = BUSY;
               else if (loadDone)        stateNext = IDLE;
      BUSY:    if (!txBusyS)             stateNext = IDLE;
      default:                           stateNext = IDLE;
    endcase
  end

  // FSM: decoded outputs
  always_comb begin
    loadTx = (state == LOAD);
    busy   = (state != IDLE);
  end

  // Grant, captured byte, pointer, timeout counter and the two pulses.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      grant    <= '0;
      grantIdx <= '0;
      txData   <= '0;
      ack      <= '0;
      timeout  <= 1'b0;
      loadCnt  <= '0;
      last     <= LW'(NUM_REQ - 1);
    end else begin
      ack     <= '0;
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          loadCnt <= '0;
          if (winValid && !txBusyS) begin
            grant    <= NUM_REQ'(1) << winIdx;
            grantIdx <= winIdx;
            txData   <= bus.ReqData[{winIdx, 3'b000} +: 8];
          end
        end
        LOAD: begin
          if (txBusyS) begin
            ack <= grant;
          end else if (loadDone) begin
            // Abandoned load: no Ack and the pointer stays where it was.
            timeout <= 1'b1;
            grant   <= '0;
          end else begin
            loadCnt <= loadCnt + 1'b1;
          end
        end
        BUSY: begin
          if (!txBusyS) begin
            grant <= '0;
            last  <= grantIdx;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.Grant   = grant;
  assign bus.Ack     = ack;
  assign bus.TxData  = txData;
  assign bus.Timeout = timeout;
  assign bus.LoadTx  = loadTx;
  assign bus.Busy    = busy;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;
  localparam int NUM_REQ      = 4;
  localparam int LOAD_TIMEOUT = 16;

  typedef struct {
    bit       isTimeout;
    int       idx;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   mdlLast;
  int   ackCnt [NUM_REQ];
  exp_t expQ [$];
  exp_t monEnt;

  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .LOAD_TIMEOUT(LOAD_TIMEOUT)
  ) dut (
    .Clk  (clk),
    .Reset(reset),
    .bus  (bus)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: first requesting index after the last served one, cyclically.
  function automatic int pickNext(input logic [NUM_REQ-1:0] mask);
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (mask[(mdlLast + k) % NUM_REQ]) return (mdlLast + k) % NUM_REQ;
    end
    return -1;
  endfunction

  // Scoreboard monitor: every Ack/Timeout pulse consumes one expectation.
  always @(negedge clk) begin
    if (!reset && (bus.Ack != 0 || bus.Timeout)) begin
      chk("ackTimeoutExclusive", (bus.Ack != 0) && bus.Timeout, 0);
      chk("ackOneHot", $onehot0(bus.Ack), 1);
      for (int i = 0; i < NUM_REQ; i++) if (bus.Ack[i]) ackCnt[i]++;
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpectedEvent: ack=%b timeout=%b with empty queue", bus.Ack, bus.Timeout);
      end else begin
        monEnt = expQ.pop_front();
        chk("eventKind", bus.Timeout, monEnt.isTimeout);
        if (!monEnt.isTimeout) begin
          chk("ackIdx", bus.Ack, 1 << monEnt.idx);
          chk("ackData", bus.TxData, monEnt.data);
        end
      end
    end
  end

  // Plays the UARTTx role for one granted transfer; called at a negedge.
  task automatic serve(input int w, input logic [7:0] dw, input bit doTo, input bit scr);
    bit seen = 0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      seen = bus.LoadTx;
    end
    chk("loadSeen", seen, 1);
    if (!seen) return;
    chk("grantAtLoad", bus.Grant, 1 << w);
    chk("txDataAtLoad", bus.TxData, dw);
    chk("busyAtLoad", bus.Busy, 1);
    if (scr) begin
      bus.ReqData[w*8 +: 8] = ~dw;
      bus.Req[w] = 1'b0;
    end
    if (doTo) begin
      repeat (LOAD_TIMEOUT - 1) @(posedge clk);
      @(negedge clk);
      chk("loadHeldPreTimeout", {bus.LoadTx, bus.Timeout}, 2'b10);
      @(posedge clk);
      @(negedge clk);
      chk("timeoutPulse", {bus.Timeout, bus.LoadTx, bus.Busy}, 3'b100);
      chk("grantClearedOnTimeout", bus.Grant, 0);
    end else begin
      repeat ($urandom_range(0, 5)) begin
        @(negedge clk);
        chk("loadHeldWaiting", bus.LoadTx, 1);
      end
      bus.TxBusy = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("preAck", {bus.LoadTx, |bus.Ack}, 2'b10);
      @(posedge clk);
      @(negedge clk);
      chk("ackCycle", {bus.LoadTx, bus.Busy, bus.Ack}, {2'b01, 4'(1 << w)});
      chk("txDataInFlight", bus.TxData, dw);
      repeat ($urandom_range(5, 30)) begin
        @(negedge clk);
        chk("grantHeld", bus.Grant, 1 << w);
      end
      bus.TxBusy = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("busyBeforeRelease", bus.Busy, 1);
      @(posedge clk);
      @(negedge clk);
      chk("releaseIdle", {bus.Busy, bus.Grant}, 0);
      mdlLast = w;
    end
  endtask

  task automatic runRound(input logic [NUM_REQ-1:0] mask, input logic [8*NUM_REQ-1:0] data,
                          input bit doTo, input bit scr);
    int w;
    exp_t e;
    bus.ReqData = data;
    bus.Req     = mask;
    w = pickNext(mask);
    e.isTimeout = doTo;
    e.idx       = w;
    e.data      = data[w*8 +: 8];
    expQ.push_back(e);
    serve(w, data[w*8 +: 8], doTo, scr);
  endtask

  initial begin
    int w;
    bit seen;
    exp_t e;
    logic [NUM_REQ-1:0] m;
    logic [8*NUM_REQ-1:0] d;

    reset = 1'b1;
    bus.Req = '0;
    bus.ReqData = '0;
    bus.TxBusy = 1'b0;
    mdlLast = NUM_REQ - 1;
    for (int i = 0; i < NUM_REQ; i++) ackCnt[i] = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("resetOutputs", {bus.Grant, bus.Ack, bus.LoadTx, bus.TxData, bus.Busy, bus.Timeout}, 0);
    reset = 1'b0;

    // Single request
    runRound(4'b0001, 32'h0000_008E, 0, 0);

    // Fairness with all four requesting continuously
    for (int i = 0; i < NUM_REQ; i++) ackCnt[i] = 0;
    repeat (8) runRound(4'b1111, 32'h4433_2211, 0, 0);
    for (int i = 0; i < NUM_REQ; i++) chk("fairAckCount", ackCnt[i], 2);

    // Timeout then the same requester again
    runRound(4'b0100, {$urandom}, 1, 0);
    runRound(4'b0100, {$urandom}, 0, 0);

    // Data captured at grant, Req dropped during LOAD
    runRound(4'b0010, 32'h0000_A500, 0, 1);

    // Stale TxBusy while idle blocks any grant
    bus.Req = '0;
    bus.TxBusy = 1'b1;
    repeat (3) @(negedge clk);
    d = {$urandom};
    bus.ReqData = d;
    bus.Req = 4'b0010;
    w = pickNext(4'b0010);
    e.isTimeout = 0; e.idx = w; e.data = d[w*8 +: 8];
    expQ.push_back(e);
    repeat (8) begin
      @(negedge clk);
      chk("noGrantWhileStale", {bus.Grant, bus.LoadTx}, 0);
    end
    bus.TxBusy = 1'b0;
    serve(w, d[w*8 +: 8], 0, 0);

    // Randomized traffic
    repeat (30) begin
      m = 4'($urandom_range(1, 15));
      runRound(m, {$urandom}, $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0);
    end

    // Reset in the middle of BUSY: pointer returns to NUM_REQ-1
    runRound(4'b0010, {$urandom}, 0, 0);
    d = {$urandom};
    bus.ReqData = d;
    bus.Req = 4'b1000;
    w = pickNext(4'b1000);
    e.isTimeout = 0; e.idx = w; e.data = d[w*8 +: 8];
    expQ.push_back(e);
    seen = 0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      seen = bus.LoadTx;
    end
    chk("rstLoadSeen", seen, 1);
    bus.TxBusy = 1'b1;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      seen = (bus.Ack != 0);
    end
    chk("rstAckSeen", seen, 1);
    @(negedge clk);
    chk("rstInBusy", bus.Busy, 1);
    reset = 1'b1;
    bus.TxBusy = 1'b0;
    bus.Req = 4'b0110;
    @(posedge clk);
    @(negedge clk);
    chk("midBusyReset", {bus.Grant, bus.Ack, bus.LoadTx, bus.TxData, bus.Busy, bus.Timeout}, 0);
    reset = 1'b0;
    mdlLast = NUM_REQ - 1;
    runRound(4'b0110, {$urandom}, 0, 0);

    bus.Req = '0;
    repeat (5) @(negedge clk);
    chk("scoreboardDrained", expQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL globalTimeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the single UARTTx transmitter among NUM_REQ byte-producing requesters. It sits between the requesters and UARTTx, driving UARTTx's LoadTx and DataIn. Because UARTTx runs on the slow BitClk, the block holds the load request until it sees TxBusy. It then waits for the frame to finish before granting the next requester. All logic runs on the system clock Clk.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- LOAD_TIMEOUT, 1024: maximum Clk cycles LoadTx is held without TxBusy being seen.

- Clk  input  1  system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Req  input  NUM_REQ  per-requester byte-pending flag.
- ReqData  input  8*NUM_REQ  byte for requester i in bits [8i+7:8i].
- Ack  output  NUM_REQ  one-cycle pulse; requester i's byte was accepted by UARTTx.
- Grant  output  NUM_REQ  one-hot; the requester currently owning the transmitter; zero when idle.
- LoadTx  output  1  to UARTTx LoadTx.
- TxData  output  8  to UARTTx DataIn; captured byte of the granted requester.
- TxBusy  input  1  from UARTTx; asynchronous to Clk, BitClk domain.
- Busy  output  1  high whenever state is not IDLE.
- Timeout  output  1  one-cycle pulse when a load is abandoned.

## Operation
- TxBusy passes through a 2-flop synchronizer; internal TxBusyS is TxBusy delayed by 2 Clk cycles. All decisions use TxBusyS only.
- Pointer `Last`, width clog2(NUM_REQ), holds the last served requester. The search order is Last+1, Last+2, … modulo NUM_REQ. The first index with Req set wins.
- States:
  - IDLE: if any Req is set and TxBusyS=0, go to LOAD. Set Grant to the winner and capture TxData from that requester's ReqData slice. If TxBusyS=1, no grant is made.
  - LOAD: LoadTx=1 and the timeout counter increments.
    - If TxBusyS=1: go to BUSY, pulse Ack[g] for one cycle, set LoadTx to 0.
    - Else if the counter reaches LOAD_TIMEOUT-1: go to IDLE, pulse Timeout, clear Grant and LoadTx. No Ack is issued and Last is unchanged.
  - BUSY: Grant is held. When TxBusyS=0, go to IDLE, clear Grant, and set Last to g.
- TxData is registered at grant. Changes to ReqData or Req after the grant have no effect on the byte in flight.
- A requester that drops Req during LOAD or BUSY still gets its byte sent and its Ack.
- A requester must keep Req high until Ack to be served. Deasserting Req before grant withdraws the request.
- The requester raising Req on the same edge that its previous Ack pulses is eligible for the next arbitration. Round-robin rotation still places it last.

## Timing
- Reset values: Grant=0, Ack=0, LoadTx=0, TxData=0, Busy=0, Timeout=0, state IDLE, Last=NUM_REQ-1 (requester 0 has first priority), timeout counter 0, synchronizer flops 0.
- Reset is sampled at any state, including mid-LOAD or mid-BUSY. The block returns to IDLE on the next edge and LoadTx drops immediately; no Ack or Timeout is issued.
- Req sampled high in IDLE at edge k (TxBusyS=0): Grant, TxData, LoadTx and Busy are valid after edge k.
- TxBusy rises at edge m: TxBusyS is high after edge m+2. The LOAD→BUSY transition and the Ack pulse occur after edge m+3.
- TxBusy falls at edge n: the block is in IDLE with Grant=0 after edge n+3. The earliest next LoadTx is after edge n+4.
- Timeout fires exactly LOAD_TIMEOUT cycles after entering LOAD if TxBusyS never rises.
- Ack and Timeout are never high in the same cycle. At most one Ack bit is set at a time.

## Test plan
- Single request: Req=4'b0001, ReqData[7:0]=8'h8E, TxBusy driven high 5 cycles after LoadTx and held 100 cycles → TxData=8'h8E, LoadTx held until TxBusyS, one Ack[0] pulse, Grant=0 three cycles after TxBusy falls.
- Round-robin fairness: Req=4'b1111 held continuously, bytes 8'h11/22/33/44 → service order 0,1,2,3,0,…; each requester gets exactly one Ack per four frames.
- Timeout: LOAD_TIMEOUT=16, Req=4'b0100, TxBusy tied 0 → Timeout pulses once 16 cycles after LoadTx rises, no Ack, next grant goes to requester 2 again.
- Data capture: grant requester 1 with 8'hA5, change ReqData slice to 8'h5A and drop Req during LOAD → TxData stays 8'hA5, Ack[1] still issued.
- Reset mid-BUSY: assert Reset one cycle during BUSY → all outputs zero next edge, Last=NUM_REQ-1, next grant goes to lowest requesting index.
- TxBusy stale high in IDLE: TxBusy=1 with Req=4'b0010 → no Grant until TxBusyS returns 0.
